if_fetch_unit: RTL and testbench

// - Instruction-fetch stage: owns the PC and issues in-order requests to instruction memory.
// - Buffers returned instructions in a FIFO and presents them to decode as if_id_*.
// - Consumes the EX-stage redirect pair (ex_take_branch_out / ex_target_PC_out) on its inputs.
// - Flushes queued and in-flight fetches on every taken branch.

---
 rtl/if_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit -- instruction-fetch stage
//
// Owns the fetch PC, issues in-order word requests to instruction memory,
// buffers the returned words (with their PCs) in a small FIFO and presents the
// FIFO head to decode. A taken branch from EX flushes the FIFO, redirects the
// PC and arranges for every response still in flight to be discarded.
//
// Parameters
//   RESET_PC  first PC fetched after reset
//   QDEPTH    FIFO entries (power of 2, >=2); also the max fetches in flight
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ex_take_branch_in        redirect request from EX
//   ex_target_PC_in          redirect target
//   id_stall_in              decode cannot accept this cycle
//   imem_req_valid/addr      fetch request (word aligned address)
//   imem_req_ready           memory accepts the request this cycle
//   imem_resp_valid/data     in-order instruction response
//   if_id_PC/NPC/IR          head entry (PC, PC+4, word; NOP when empty)
//   if_id_valid_inst         head entry valid
//   if_misalign_out          sticky misaligned-redirect flag
//                            (only when IF_MISALIGN_TRAP_EN is defined)
//
// Build option
//   IF_MISALIGN_TRAP_EN  when defined, a redirect to a non-word-aligned target
//                        raises if_misalign_out and halts fetching until the
//                        next aligned redirect. When undefined the port is
//                        absent and the target's low two bits are ignored.
// -----------------------------------------------------------------------------
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          QDEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_take_branch_in,
   input  logic [31:0] ex_target_PC_in,
   input  logic        id_stall_in,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic [31:0] if_id_PC,
   output logic [31:0] if_id_NPC,
   output logic [31:0] if_id_IR,
   output logic        if_id_valid_inst
`ifdef IF_MISALIGN_TRAP_EN
   ,
   output logic        if_misalign_out
`endif
);

   localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = AW + 1;
   // Drops can pile up across back-to-back redirects against a slow memory,
   // so the drop counter is made wider than the credit counters.
   localparam int DW = 16;
   localparam logic [CW:0]  QDEPTH_W = (CW + 1)'(QDEPTH);
   localparam logic [31:0]  NOP      = 32'h0000_0013;

   logic [31:0]   fetch_pc;
   logic [31:0]   inflight_pc [QDEPTH];
   logic [31:0]   pc_mem      [QDEPTH];
   logic [31:0]   ir_mem      [QDEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr, pq_rd, pq_wr;
   logic [CW-1:0] fifo_count, outstanding;
   logic [DW-1:0] drop_cnt;
   logic [CW:0]   in_use;
   logic [31:0]   target_aligned;
   logic          misalign;
   logic          redirect, req_fire, resp_keep, resp_drop, head_valid, pop;

   assign redirect       = ex_take_branch_in;
   assign target_aligned = ex_target_PC_in & ~32'h3;

   // Credit: buffered plus in-flight entries never exceed the FIFO depth,
   // so every accepted response is guaranteed a free slot.
   assign in_use         = {1'b0, fifo_count} + {1'b0, outstanding};
   assign imem_req_valid = !rst && !redirect && !misalign && (in_use < QDEPTH_W);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response in the redirect cycle is covered by the drop accounting below.
   assign resp_keep  = imem_resp_valid && !redirect && (drop_cnt == '0);
   assign resp_drop  = imem_resp_valid && !redirect && (drop_cnt != '0);

   assign head_valid = (fifo_count != '0);
   assign pop        = head_valid && !id_stall_in && !redirect;

   assign if_id_valid_inst = head_valid;
   assign if_id_PC         = head_valid ? pc_mem[rd_ptr] : 32'h0;
   assign if_id_IR         = head_valid ? ir_mem[rd_ptr] : NOP;
   assign if_id_NPC        = if_id_PC + 32'd4;

   // ---- control state: PC, pointers, credit and drop counters ----
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         pq_rd       <= '0;
         pq_wr       <= '0;
         fifo_count  <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else if (redirect) begin
         // Everything in flight (minus a response landing right now) becomes
         // a future drop, on top of drops still pending from earlier redirects.
         fetch_pc    <= target_aligned;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         pq_rd       <= '0;
         pq_wr       <= '0;
         fifo_count  <= '0;
         outstanding <= '0;
         drop_cnt    <= drop_cnt + DW'(outstanding) - DW'(imem_resp_valid);
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
            pq_wr    <= pq_wr + AW'(1);
         end
         if (resp_drop) drop_cnt <= drop_cnt - DW'(1);
         if (resp_keep) begin
            wr_ptr <= wr_ptr + AW'(1);
            pq_rd  <= pq_rd + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         outstanding <= outstanding + CW'(req_fire) - CW'(resp_keep);
         fifo_count  <= fifo_count + CW'(resp_keep) - CW'(pop);
      end
   end

   // ---- data storage: in-flight PCs and the instruction FIFO ----
   always_ff @(posedge clk) begin
      if (req_fire) inflight_pc[pq_wr] <= fetch_pc;
      if (resp_keep) begin
         pc_mem[wr_ptr] <= inflight_pc[pq_rd];
         ir_mem[wr_ptr] <= imem_resp_data;
      end
   end

`ifdef IF_MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (rst)           misalign <= 1'b0;
      else if (redirect) misalign <= (ex_target_PC_in[1:0] != 2'b00);
   end
   assign if_misalign_out = misalign;
`else
   assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
   localparam int          QDEPTH   = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_take_branch_in;
   logic [31:0] ex_target_PC_in;
   logic        id_stall_in;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic [31:0] if_id_PC, if_id_NPC, if_id_IR;
   logic        if_id_valid_inst;
`ifdef IF_MISALIGN_TRAP_EN
   logic        if_misalign_out;
`endif

   if_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
      .clk(clk), .rst(rst),
      .ex_take_branch_in(ex_take_branch_in), .ex_target_PC_in(ex_target_PC_in),
      .id_stall_in(id_stall_in),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .if_id_PC(if_id_PC), .if_id_NPC(if_id_NPC), .if_id_IR(if_id_IR),
      .if_id_valid_inst(if_id_valid_inst)
`ifdef IF_MISALIGN_TRAP_EN
      , .if_misalign_out(if_misalign_out)
`endif
   );

   always #5 clk = ~clk;

   // Memory contents: a fixed scramble of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   typedef struct { logic [31:0] pc; logic [31:0] ir; } exp_t;
   typedef struct { logic [31:0] data; int due; } resp_t;

   exp_t  exp_q[$];   // decode stream the model predicts
   resp_t pend[$];    // memory responses waiting to be returned

   int checks = 0, errors = 0;
   int pops = 0, total_acc = 0, live_acc = 0, live_pop = 0;
   int cyc = 0, lat_lo = 1, lat_hi = 1;
   logic [31:0] next_exp, exp_fetch, addr_prev;
   bit blocked = 0, rst_prev = 1, redir_prev = 0, hold_prev = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: after reset or a redirect, decode must see the
   // sequential word stream starting at the (word-aligned) target.
   task automatic restart(input logic [31:0] t);
      exp_q.delete();
`ifdef IF_MISALIGN_TRAP_EN
      blocked = (t[1:0] != 2'b00);
`else
      blocked = 0;
`endif
      next_exp = t & ~32'h3;
   endtask

   task automatic topup();
      if (!blocked)
         while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: next_exp, ir: mem_word(next_exp)});
            next_exp += 32'd4;
         end
   endtask

   task automatic step(input bit r, input bit br, input logic [31:0] t, input bit st, input bit rdy);
      @(posedge clk); #1;
      rst = r; ex_take_branch_in = br; ex_target_PC_in = t;
      id_stall_in = st; imem_req_ready = rdy;
      if (r) restart(RESET_PC);
      else if (br) restart(t);
      topup();
   endtask

   task automatic idle(); step(0, 0, 32'h0, 0, 1); endtask
   task automatic do_reset(); step(1, 0, 32'h0, 0, 1); step(1, 0, 32'h0, 0, 1); endtask

   task automatic wait_valid(output bit ok);
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         idle();
         @(negedge clk);
         if (if_id_valid_inst) begin ok = 1; break; end
      end
   endtask

   // Memory model: in-order, latency lat_lo..lat_hi cycles, reset with the DUT.
   initial begin
      imem_resp_valid = 0; imem_resp_data = 32'h0;
      forever begin
         @(negedge clk);
         if (rst) pend.delete();
         else if (imem_req_valid && imem_req_ready)
            pend.push_back('{data: mem_word(imem_req_addr),
                             due: cyc + int'($urandom_range(lat_hi, lat_lo))});
         @(posedge clk);
         cyc++;
         #2;
         if (!rst && pend.size() > 0 && pend[0].due <= cyc &&
             (lat_hi == lat_lo || $urandom_range(0, 3) != 0)) begin
            imem_resp_valid = 1;
            imem_resp_data  = pend[0].data;
            void'(pend.pop_front());
         end else begin
            imem_resp_valid = 0;
            imem_resp_data  = $urandom;
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            if (rst_prev) begin
               chk("rst_valid", 32'(if_id_valid_inst), 32'h0);
               chk("rst_pc", if_id_PC, 32'h0);
               chk("rst_ir", if_id_IR, NOP);
               chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
`ifdef IF_MISALIGN_TRAP_EN
               chk("rst_misalign", 32'(if_misalign_out), 32'h0);
`endif
            end
            exp_fetch = RESET_PC; live_acc = 0; live_pop = 0;
         end else begin
            if (redir_prev) chk("valid_after_redirect", 32'(if_id_valid_inst), 32'h0);
            if (hold_prev && !ex_take_branch_in) begin
               chk("req_hold_valid", 32'(imem_req_valid), 32'h1);
               chk("req_hold_addr", imem_req_addr, addr_prev);
            end
            if (ex_take_branch_in) begin
               chk("req_in_redirect", 32'(imem_req_valid), 32'h0);
               exp_fetch = ex_target_PC_in & ~32'h3;
               live_acc = 0; live_pop = 0;
            end else begin
`ifdef IF_MISALIGN_TRAP_EN
               chk("misalign_flag", 32'(if_misalign_out), 32'(blocked));
`endif
               if (blocked) chk("req_while_misaligned", 32'(imem_req_valid), 32'h0);
               if (imem_req_valid && imem_req_ready) begin
                  chk("req_addr", imem_req_addr, exp_fetch);
                  exp_fetch += 32'd4;
                  live_acc++; total_acc++;
               end
               if (if_id_valid_inst) begin
                  if (exp_q.size() == 0) chk("unexpected_valid", 32'(if_id_valid_inst), 32'h0);
                  else begin
                     chk("if_id_PC", if_id_PC, exp_q[0].pc);
                     chk("if_id_IR", if_id_IR, exp_q[0].ir);
                     chk("if_id_NPC", if_id_NPC, exp_q[0].pc + 32'd4);
                     if (!id_stall_in) begin
                        void'(exp_q.pop_front());
                        pops++; live_pop++;
                     end
                  end
               end
               chk("credit", 32'(live_acc - live_pop <= QDEPTH), 32'h1);
            end
         end
         rst_prev   = rst;
         redir_prev = !rst && ex_take_branch_in;
         hold_prev  = !rst && imem_req_valid && !imem_req_ready;
         addr_prev  = imem_req_addr;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      int acc0;
      logic [31:0] rv, t;
      rst = 1; ex_take_branch_in = 0; ex_target_PC_in = 0; id_stall_in = 0; imem_req_ready = 0;

      // Straight-line fetch, one-cycle memory: first decode valid two cycles after reset
      do_reset();
      idle(); @(negedge clk); chk("t1_valid_c0", 32'(if_id_valid_inst), 32'h0);
      idle(); @(negedge clk); chk("t1_valid_c1", 32'(if_id_valid_inst), 32'h0);
      idle(); @(negedge clk); chk("t1_valid_c2", 32'(if_id_valid_inst), 32'h1);
      chk("t1_first_pc", if_id_PC, 32'h0);
      idle(); @(negedge clk); chk("t1_second_pc", if_id_PC, 32'h4);
      repeat (6) idle();

      // Decode stalled: exactly QDEPTH fetches, then requests stop
      do_reset();
      acc0 = total_acc;
      repeat (10) step(0, 0, 32'h0, 1, 1);
      @(negedge clk);
      chk("t2_accepted", 32'(total_acc - acc0), 32'(QDEPTH));
      chk("t2_req_low", 32'(imem_req_valid), 32'h0);
      chk("t2_head_pc", if_id_PC, 32'h0);
      repeat (20) idle();

      // Two in flight, redirect to 0x100
      lat_lo = 3; lat_hi = 3;
      do_reset();
      idle(); idle();
      step(0, 1, 32'h100, 0, 1);
      wait_valid(ok);
      chk("t3_got_valid", 32'(ok), 32'h1);
      chk("t3_pc", if_id_PC, 32'h100);
      chk("t3_ir", if_id_IR, mem_word(32'h100));
      repeat (6) idle();

      // Redirect with a response in the same cycle, then a second redirect
      lat_lo = 2; lat_hi = 2;
      do_reset();
      idle(); idle(); idle();
      step(0, 1, 32'h100, 0, 1);
      step(0, 1, 32'h200, 0, 1);
      wait_valid(ok);
      chk("t4_got_valid", 32'(ok), 32'h1);
      chk("t4_pc", if_id_PC, 32'h200);
      chk("t4_ir", if_id_IR, mem_word(32'h200));
      repeat (6) idle();

      // Memory not ready for three cycles
      lat_lo = 1; lat_hi = 1;
      do_reset();
      repeat (3) step(0, 0, 32'h0, 0, 0);
      @(negedge clk);
      chk("t5_addr_held", imem_req_addr, 32'h0);
      chk("t5_req_valid", 32'(imem_req_valid), 32'h1);
      repeat (12) idle();

      // Misaligned redirect
      do_reset();
      repeat (3) idle();
      step(0, 1, 32'h102, 0, 1);
`ifdef IF_MISALIGN_TRAP_EN
      repeat (4) idle();
      @(negedge clk);
      chk("t6_flag_set", 32'(if_misalign_out), 32'h1);
      chk("t6_no_req", 32'(imem_req_valid), 32'h0);
      step(0, 1, 32'h200, 0, 1);
      wait_valid(ok);
      chk("t6_got_valid", 32'(ok), 32'h1);
      chk("t6_flag_clear", 32'(if_misalign_out), 32'h0);
      chk("t6_pc", if_id_PC, 32'h200);
`else
      wait_valid(ok);
      chk("t6_got_valid", 32'(ok), 32'h1);
      chk("t6_pc", if_id_PC, 32'h100);
`endif
      repeat (6) idle();

      // Randomized traffic
      lat_lo = 1; lat_hi = 4;
      acc0 = pops;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 999) < 3) do_reset();
         else begin
            rv = $urandom;
            case ($urandom_range(0, 3))
               0:       t = rv;
               1:       t = 32'hFFFF_FFF0 | (rv & 32'hF);
               2:       t = rv & 32'h0000_FFFC;
               default: t = 32'h200;
            endcase
            step(0, $urandom_range(0, 99) < 3, t,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
         end
      end
      repeat (20) idle();
      chk("random_progress", 32'(pops - acc0 > 200), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
